// File: rtl/adaptive_filter_out_buf.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------------+
// | adaptive_filter_out_buf: settle-discard gate plus FWFT FIFO for filter output |
// | Optional macro ADAPTIVE_OUT_DROP_CNT_EN adds the drop_cnt port.  Rev 1.0       |
// +------------------------------------------------------------------------------+
module adaptive_filter_out_buf #(
    parameter int DATA_WIDTH     = 14,
    parameter int DEPTH          = 16,
    parameter int SETTLE_SAMPLES = 8
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    ctrl,
    input  logic                    s_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tuser,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    settling,
    output logic                    overflow,
    input  logic                    ovf_clr
`ifdef ADAPTIVE_OUT_DROP_CNT_EN
    ,
    output logic [15:0]             drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SETTLE_SAMPLES + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_SAMPLES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [AW:0]   FULL_LEVEL  = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t                  state;
    logic [CW-1:0]           discard_cnt;
    logic                    ctrl_q;
    logic [DATA_WIDTH:0]     mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             level;

    logic mode_change;
    logic discarding;
    logic wr_req;
    logic full;
    logic rd;
    logic wr;
    logic drop;

    // The sample arriving with the mode change is the first of the discarded ones.
    assign mode_change = (ctrl != ctrl_q);
    assign discarding  = mode_change || ((state == SETTLE) && (discard_cnt != '0));
    assign wr_req      = s_tvalid && !discarding;
    assign full        = (level == FULL_LEVEL);
    assign rd          = m_tvalid && m_tready;
    assign wr          = wr_req && (!full || rd);
    assign drop        = wr_req && full && !rd;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= SETTLE;
            discard_cnt <= SETTLE_LOAD;
            ctrl_q      <= 1'b0;
        end else begin
            ctrl_q <= ctrl;
            if (mode_change) begin
                state       <= SETTLE;
                discard_cnt <= s_tvalid ? (SETTLE_LOAD - CNT_ONE) : SETTLE_LOAD;
            end else if (state == SETTLE) begin
                if (discard_cnt == '0) begin
                    state <= RUN;
                end else if (s_tvalid) begin
                    discard_cnt <= discard_cnt - CNT_ONE;
                    if (discard_cnt == CNT_ONE) begin
                        state <= RUN;
                    end
                end
            end
        end
    end

    // Storage is not reset; the read port is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= {ctrl_q, s_tdata};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef ADAPTIVE_OUT_DROP_CNT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (ovf_clr) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt <= '0;
        end
    end
`endif

    assign m_tvalid            = (level != '0);
    assign {m_tuser, m_tdata}  = m_tvalid ? mem[rd_ptr] : '0;
    assign fifo_level          = level;
    assign settling            = (state == SETTLE);

endmodule
`default_nettype wire

// File: tb/tb_adaptive_filter_out_buf.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for adaptive_filter_out_buf: queue-based reference model checked every
// negedge, plus directed scenarios with hand-computed expectations.
module tb_adaptive_filter_out_buf;

    localparam int DW     = 14;
    localparam int DEPTH  = 16;
    localparam int SETTLE = 8;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          ctrl;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tuser;
    logic [4:0]    fifo_level;
    logic          settling;
    logic          overflow;
    logic          ovf_clr;
`ifdef ADAPTIVE_OUT_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    adaptive_filter_out_buf #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .SETTLE_SAMPLES (SETTLE)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .ctrl       (ctrl),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tuser    (m_tuser),
        .fifo_level (fifo_level),
        .settling   (settling),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
`ifdef ADAPTIVE_OUT_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: queue of {mode, sample} entries and settle bookkeeping.
    logic [DW:0] q[$];
    int  remaining;
    bit  in_settle;
    bit  prev_ctrl;
    bit  m_ovf;
    int  m_drops;
    bit  do_pop;
    bit  do_push;
    bit  do_drop;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q.delete();
            remaining = SETTLE;
            in_settle = 1'b1;
            prev_ctrl = 1'b0;
            m_ovf     = 1'b0;
            m_drops   = 0;
        end else begin
            do_pop  = (q.size() > 0) && m_tready;
            do_push = 1'b0;
            do_drop = 1'b0;
            if (ctrl != prev_ctrl) begin
                in_settle = 1'b1;
                remaining = SETTLE;
                if (s_tvalid) remaining = remaining - 1;
            end else if (in_settle) begin
                if (s_tvalid && remaining > 0) remaining = remaining - 1;
                if (remaining == 0) in_settle = 1'b0;
            end else if (s_tvalid) begin
                if (q.size() == DEPTH && !do_pop) do_drop = 1'b1;
                else do_push = 1'b1;
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({prev_ctrl, s_tdata});
            if (do_drop) begin
                m_ovf = 1'b1;
                m_drops = ovf_clr ? 1 : ((m_drops < 65535) ? m_drops + 1 : m_drops);
            end else if (ovf_clr) begin
                m_ovf = 1'b0;
                m_drops = 0;
            end
            prev_ctrl = ctrl;
        end
    end

    always @(negedge clk) begin
        chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, q.size() != 0});
        chk("fifo_level", {27'd0, fifo_level}, q.size());
        if (q.size() > 0) begin
            chk("m_tdata", {18'd0, m_tdata}, {18'd0, q[0][DW-1:0]});
            chk("m_tuser", {31'd0, m_tuser}, {31'd0, q[0][DW]});
        end
        chk("settling", {31'd0, settling}, {31'd0, in_settle});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef ADAPTIVE_OUT_DROP_CNT_EN
        chk("drop_cnt", {16'd0, drop_cnt}, m_drops);
`endif
    end

    task automatic send(input int d);
        s_tvalid = 1'b1;
        s_tdata  = DW'(d);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n = 1'b0; ctrl = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
        m_tready = 1'b1; ovf_clr = 1'b0;
        #1;
        chk("rst_settling", {31'd0, settling}, 32'd1);
        chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_level", {27'd0, fifo_level}, 32'd0);
        chk("rst_m_tdata", {18'd0, m_tdata}, 32'd0);
        chk("rst_m_tuser", {31'd0, m_tuser}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        // Initial settle: 0..7 discarded, 8 is the first output.
        for (int i = 0; i < 8; i++) begin
            send(i);
            if (i == 6) chk("settle_before_last", {31'd0, settling}, 32'd1);
            chk("settle_no_out", {31'd0, m_tvalid}, 32'd0);
        end
        chk("settle_exit", {31'd0, settling}, 32'd0);
        send(8);
        chk("first_out_valid", {31'd0, m_tvalid}, 32'd1);
        chk("first_out_data", {18'd0, m_tdata}, 32'd8);
        chk("first_out_user", {31'd0, m_tuser}, 32'd0);
        for (int i = 9; i < 20; i++) send(i);

        // Single toggle at 20: resume at 28 in mode 1.
        ctrl = 1'b1;
        for (int i = 20; i < 28; i++) send(i);
        chk("toggle_gap", {31'd0, m_tvalid}, 32'd0);
        send(28);
        chk("toggle_resume_data", {18'd0, m_tdata}, 32'd28);
        chk("toggle_resume_user", {31'd0, m_tuser}, 32'd1);
        for (int i = 29; i < 60; i++) send(i);

        // Toggle at 60 and again at 64: resume at 72.
        ctrl = 1'b0;
        for (int i = 60; i < 64; i++) send(i);
        ctrl = 1'b1;
        for (int i = 64; i < 72; i++) send(i);
        chk("retoggle_gap", {31'd0, m_tvalid}, 32'd0);
        send(72);
        chk("retoggle_resume_data", {18'd0, m_tdata}, 32'd72);
        chk("retoggle_resume_user", {31'd0, m_tuser}, 32'd1);
        idle(2);
        chk("drained", {27'd0, fifo_level}, 32'd0);

        // Fill with no reads: 16 kept, 4 dropped.
        m_tready = 1'b0;
        for (int k = 0; k < 20; k++) send(100 + k);
        chk("full_level", {27'd0, fifo_level}, 32'd16);
        chk("full_overflow", {31'd0, overflow}, 32'd1);
`ifdef ADAPTIVE_OUT_DROP_CNT_EN
        chk("full_drop_cnt", {16'd0, drop_cnt}, 32'd4);
`endif
        m_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("drain_order", {18'd0, m_tdata}, 32'(100 + k));
            idle(1);
        end
        chk("drain_empty", {31'd0, m_tvalid}, 32'd0);

        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full with simultaneous read and write: no drop.
        m_tready = 1'b0;
        for (int k = 0; k < 16; k++) send(200 + k);
        chk("refill_level", {27'd0, fifo_level}, 32'd16);
        m_tready = 1'b1;
        send(216);
        chk("rw_full_level", {27'd0, fifo_level}, 32'd16);
        chk("rw_full_ovf", {31'd0, overflow}, 32'd0);
        chk("rw_full_head", {18'd0, m_tdata}, 32'd201);

        // Set beats clear when they coincide.
        m_tready = 1'b0;
        send(217);
        chk("drop_sets_ovf", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        send(218);
        ovf_clr = 1'b0;
        chk("set_wins", {31'd0, overflow}, 32'd1);
`ifdef ADAPTIVE_OUT_DROP_CNT_EN
        chk("set_wins_cnt", {16'd0, drop_cnt}, 32'd1);
`endif
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("clr_alone", {31'd0, overflow}, 32'd0);

        // Asynchronous reset with 5 entries buffered.
        m_tready = 1'b1;
        idle(17);
        chk("predrain", {27'd0, fifo_level}, 32'd0);
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) send(300 + k);
        chk("five_level", {27'd0, fifo_level}, 32'd5);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("arst_level", {27'd0, fifo_level}, 32'd0);
        chk("arst_settling", {31'd0, settling}, 32'd1);
        ctrl = 1'b0;
        m_tready = 1'b1;
        @(posedge clk);
        #1 arst_n = 1'b1;
        for (int i = 400; i < 408; i++) begin
            send(i);
            chk("post_rst_discard", {31'd0, m_tvalid}, 32'd0);
        end
        chk("post_rst_settle_exit", {31'd0, settling}, 32'd0);
        send(408);
        chk("post_rst_first_data", {18'd0, m_tdata}, 32'd408);
        chk("post_rst_first_user", {31'd0, m_tuser}, 32'd0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adaptive_filter_out_buf.md
ADAPTIVE_FILTER_OUT_BUF -- requirements
Module: adaptive_filter_out_buf

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_WIDTH, default 14: sample width in bits, matching the filter output.
REQ-003 Parameter DEPTH, default 16: FIFO depth in samples, power of two, minimum 4.
REQ-004 Parameter SETTLE_SAMPLES, default 8: number of valid samples discarded after a mode change, minimum 1.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port arst_n, input, 1: asynchronous active-low reset.
REQ-007 Port ctrl, input, 1: filter mode, 1 = integrator, 0 = differentiator; same signal that drives the filter.
REQ-008 Port s_tvalid, input, 1: filter output sample valid.
REQ-009 Port s_tdata, input, DATA_WIDTH: filter output sample, two's complement.
REQ-010 Port m_tvalid, output, 1: output sample available.
REQ-011 Port m_tready, input, 1: downstream accepts the sample.
REQ-012 Port m_tdata, output, DATA_WIDTH: buffered sample.
REQ-013 Port m_tuser, output, 1: mode (ctrl value) under which m_tdata was captured.
REQ-014 Port fifo_level, output, $clog2(DEPTH)+1: current FIFO occupancy.
REQ-015 Port settling, output, 1: high while in SETTLE state.
REQ-016 Port overflow, output, 1: sticky flag, sample dropped because FIFO was full.
REQ-017 Port ovf_clr, input, 1: single-cycle clear of overflow.

Function
REQ-018 The block SHALL register ctrl every cycle into ctrl_q; a mode change SHALL be detected when ctrl differs from ctrl_q.
REQ-019 The FSM SHALL have two states, SETTLE and RUN; settling SHALL equal (state == SETTLE).
REQ-020 On a mode change in any state, the FSM SHALL enter SETTLE and load the discard counter with SETTLE_SAMPLES.
REQ-021 In SETTLE, each cycle with s_tvalid SHALL decrement the counter and discard the sample; the sample that decrements it to 0 SHALL also be discarded, and the FSM SHALL go to RUN on the next cycle.
REQ-022 A mode change coinciding with the final discard SHALL take priority: the FSM SHALL stay in SETTLE with the counter reloaded.
REQ-023 In RUN, a sample with s_tvalid SHALL be written to the FIFO with m_tuser = ctrl_q, unless the FIFO is full with no read in the same cycle.
REQ-024 A write when full SHALL be accepted if a read (m_tvalid && m_tready) occurs in the same cycle; fifo_level SHALL be unchanged.
REQ-025 A write when full with no read SHALL drop the sample and set overflow; the FIFO contents SHALL be unchanged.
REQ-026 overflow SHALL clear on ovf_clr; when set and clear coincide, set SHALL win.
REQ-027 m_tvalid SHALL equal (fifo_level != 0); the FIFO SHALL be first-word-fall-through.
REQ-028 The first write into an empty FIFO SHALL raise m_tvalid one cycle after the write cycle; there SHALL be no same-cycle bypass.
REQ-029 m_tdata and m_tuser SHALL hold stable while m_tvalid && !m_tready.
REQ-030 Samples SHALL leave in write order, bit-exact; the block SHALL perform no arithmetic on data.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-032 While arst_n is low, outputs SHALL be: m_tvalid=0, m_tdata=0, m_tuser=0, fifo_level=0, overflow=0, settling=1.
REQ-033 Reset SHALL place the FSM in SETTLE with counter = SETTLE_SAMPLES and ctrl_q = 0; reset mid-operation SHALL discard all FIFO contents.

Configuration
REQ-034 Macro ADAPTIVE_OUT_DROP_CNT_EN defined: the block SHALL add output port drop_cnt[15:0], incremented on each dropped sample, saturating at 16'hFFFF, reset to 0, cleared by ovf_clr (increment wins on coincidence, giving 1).
REQ-035 Macro ADAPTIVE_OUT_DROP_CNT_EN not defined: port drop_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 Reset release, ctrl=0, s_tvalid=1 with ramp 0,1,2,...; m_tready=1 -> samples 0..7 discarded, first output m_tdata=8 with m_tuser=0, settling deasserted after the 8th valid sample.
REQ-037 In RUN, toggle ctrl to 1 at sample 20 -> samples 20..27 discarded, output resumes at 28 with m_tuser=1; a second toggle at sample 24 -> output resumes at 32.
REQ-038 m_tready=0, 20 valid samples in RUN -> fifo_level reaches 16, samples 17..20 dropped, overflow=1 (drop_cnt=4 with macro); then m_tready=1 -> exactly the first 16 samples are output, in order.
REQ-039 FIFO full, s_tvalid=1 and m_tready=1 in the same cycle -> no drop, fifo_level stays 16, overflow stays 0.
REQ-040 overflow=1, ovf_clr pulsed together with a new drop -> overflow stays 1; ovf_clr alone -> overflow=0 next cycle.
REQ-041 arst_n pulsed low with 5 entries buffered -> m_tvalid=0 and fifo_level=0 immediately (asynchronously), settling=1, the next 8 valid samples are discarded.
